// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of one shared WIDTH-bit tri-state bus: bounded hold, high-Z turnaround between owners.
// Latency: data sampled at an edge is on the bus after that edge; requesters are never stalled, only wait for grant.
module tristate_bus_arbiter #(
  parameter int N_CH        = 4,
  parameter int WIDTH       = 8,
  parameter int MAX_HOLD    = 4,
  parameter int TURN_CYCLES = 1,
  parameter int INVERT      = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_CH-1:0]            req,
  input  logic [N_CH*WIDTH-1:0]      data_in,
  output logic [N_CH-1:0]            grant,
  output logic [$clog2(N_CH)-1:0]    owner_id,
  output logic                       drive_n,
  output tri   [WIDTH-1:0]           bus_out
);

  localparam int ID_W   = $clog2(N_CH);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int TURN_W = $clog2(TURN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic [WIDTH-1:0]  data_q, data_d;

  logic              arb_vld;
  logic [ID_W-1:0]   arb_idx;
  logic              any_other;
  logic              release_now;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    arb_vld = 1'b0;
    arb_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!arb_vld && req[(int'(ptr_q) + i) % N_CH]) begin
        arb_vld = 1'b1;
        arb_idx = ID_W'((int'(ptr_q) + i) % N_CH);
      end
    end
  end

  assign any_other   = |(req & ~grant_q);
  assign release_now = !req[owner_q] || ((hold_q == HOLD_W'(MAX_HOLD)) && any_other);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    data_d  = data_q;

    case (state_q)
      DRIVE: begin
        if (release_now) begin
          state_d = TURN;
          grant_d = '0;
          ptr_d   = (owner_q == ID_W'(N_CH - 1)) ? '0 : owner_q + 1'b1;
          turn_d  = TURN_W'(1);
        end else begin
          if (hold_q != HOLD_W'(MAX_HOLD)) begin
            hold_d = hold_q + 1'b1;
          end
          data_d = data_in[owner_q*WIDTH +: WIDTH];
        end
      end

      default: begin
        // IDLE arbitrates every edge; TURN only once the turnaround has elapsed.
        if (state_q == TURN && turn_q < TURN_W'(TURN_CYCLES)) begin
          turn_d = turn_q + 1'b1;
        end else if (arb_vld) begin
          state_d = DRIVE;
          grant_d = {{(N_CH-1){1'b0}}, 1'b1} << arb_idx;
          owner_d = arb_idx;
          hold_d  = HOLD_W'(1);
          turn_d  = '0;
          data_d  = data_in[arb_idx*WIDTH +: WIDTH];
        end else begin
          state_d = IDLE;
          turn_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      data_q  <= data_d;
    end
  end

  assign grant    = grant_q;
  assign owner_id = owner_q;
  assign drive_n  = ~|grant_q;
  assign bus_out  = drive_n ? {WIDTH{1'bz}} : ((INVERT != 0) ? ~data_q : data_q);

  grant_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant_q));

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: directed scenarios plus random traffic against a cycle-level model.
module tb_tristate_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rst_b_n;
  logic [3:0]  req_a, req_b;
  logic [31:0] din_a, din_b;
  logic [3:0]  grant_a, grant_b;
  logic [1:0]  own_a, own_b;
  logic        dn_a, dn_b;
  tri   [7:0]  bus_a, bus_b;

  tristate_bus_arbiter #(.N_CH(4), .WIDTH(8), .MAX_HOLD(4), .TURN_CYCLES(1), .INVERT(1)) dut_a (
    .clk(clk), .reset_n(rst_a_n), .req(req_a), .data_in(din_a),
    .grant(grant_a), .owner_id(own_a), .drive_n(dn_a), .bus_out(bus_a));

  tristate_bus_arbiter #(.N_CH(4), .WIDTH(8), .MAX_HOLD(4), .TURN_CYCLES(2), .INVERT(0)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .req(req_b), .data_in(din_b),
    .grant(grant_b), .owner_id(own_b), .drive_n(dn_b), .bus_out(bus_b));

  int checks = 0;
  int errors = 0;

  // Model: owner (-1 = bus released), cycles owned, Z cycles still owed, search start, last owner, data.
  int         m_owner[2];
  int         m_held[2];
  int         m_zleft[2];
  int         m_ptr[2];
  int         m_last[2];
  logic [7:0] m_data[2];
  int         turn_c[2] = '{1, 2};
  bit         inv_c[2]  = '{1'b1, 1'b0};

  task automatic model_step(input int u, input logic rn, input logic [3:0] r, input logic [31:0] d);
    logic [3:0] others;
    bit found;
    int k;
    if (!rn) begin
      m_owner[u] = -1; m_held[u] = 0; m_zleft[u] = 0;
      m_ptr[u] = 0; m_last[u] = 0; m_data[u] = 8'h00;
    end else if (m_owner[u] >= 0) begin
      others = r;
      others[m_owner[u]] = 1'b0;
      if (!r[m_owner[u]] || (m_held[u] >= 4 && others != 4'b0)) begin
        m_ptr[u]   = (m_owner[u] + 1) % 4;
        m_owner[u] = -1;
        m_zleft[u] = turn_c[u];
      end else begin
        m_held[u] = m_held[u] + 1;
        m_data[u] = d[8*m_owner[u] +: 8];
      end
    end else if (m_zleft[u] > 1) begin
      m_zleft[u] = m_zleft[u] - 1;
    end else begin
      found = 1'b0;
      m_zleft[u] = 0;
      for (int i = 0; i < 4; i++) begin
        k = (m_ptr[u] + i) % 4;
        if (!found && r[k]) begin
          found = 1'b1;
          m_owner[u] = k; m_last[u] = k; m_held[u] = 1;
          m_data[u] = d[8*k +: 8];
        end
      end
    end
  endtask

  function automatic logic [14:0] exp_vec(input int u);
    logic [3:0] g;
    logic [7:0] b;
    g = 4'b0;
    b = 8'h00;
    if (m_owner[u] >= 0) begin
      g[m_owner[u]] = 1'b1;
      b = inv_c[u] ? ~m_data[u] : m_data[u];
    end
    return {g, 2'(m_last[u]), (m_owner[u] < 0), b};
  endfunction

  function automatic logic [14:0] obs_a();
    return {grant_a, own_a, dn_a, dn_a ? 8'h00 : bus_a};
  endfunction

  function automatic logic [14:0] obs_b();
    return {grant_b, own_b, dn_b, dn_b ? 8'h00 : bus_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0, rst_a_n, req_a, din_a);
    model_step(1, rst_b_n, req_b, din_b);
    #1;
  endtask

  task automatic test_reset();
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      req_a = 4'($urandom_range(0, 15)); req_b = 4'($urandom_range(0, 15));
      din_a = $urandom; din_b = $urandom;
      tick();
      checks++;
      if ({grant_a, own_a, dn_a} !== 7'b0000_00_1) begin
        errors++; $display("FAIL reset_a grant/owner/drive_n got=%b exp=0000_00_1", {grant_a, own_a, dn_a});
      end
      checks++;
      if ({grant_b, own_b, dn_b} !== 7'b0000_00_1) begin
        errors++; $display("FAIL reset_b grant/owner/drive_n got=%b exp=0000_00_1", {grant_b, own_b, dn_b});
      end
    end
    rst_a_n = 1'b1; rst_b_n = 1'b1; req_a = 4'b0; req_b = 4'b0;
    tick();
  endtask

  task automatic test_single();
    req_a = 4'b0100;
    din_a = $urandom;
    din_a[23:16] = 8'hA5;
    tick();
    checks++;
    if ({grant_a, own_a, dn_a, bus_a} !== {4'b0100, 2'd2, 1'b0, 8'h5A}) begin
      errors++; $display("FAIL single_grant got=%h exp=%h", {grant_a, own_a, dn_a, bus_a}, {4'b0100, 2'd2, 1'b0, 8'h5A});
    end
    din_a[23:16] = 8'h0F;
    tick();
    checks++;
    if (bus_a !== 8'hF0) begin
      errors++; $display("FAIL single_data_update bus got=%h exp=f0", bus_a);
    end
    for (int c = 0; c < 6; c++) begin
      din_a = $urandom;
      tick();
      checks++;
      if (grant_a !== 4'b0100 || obs_a() !== exp_vec(0)) begin
        errors++; $display("FAIL single_hold cyc=%0d got=%h exp=%h", c, obs_a(), exp_vec(0));
      end
    end
    req_a = 4'b0;
    tick(); tick();
  endtask

  task automatic test_hold_limit();
    int exp_own[11] = '{0, 0, 0, 0, -1, 3, 3, 3, 3, -1, 0};
    logic [3:0] g;
    rst_a_n = 1'b0; tick(); rst_a_n = 1'b1;
    req_a = 4'b1001;
    for (int c = 0; c < 11; c++) begin
      din_a = $urandom;
      tick();
      g = (exp_own[c] < 0) ? 4'b0 : 4'(1 << exp_own[c]);
      checks++;
      if (grant_a !== g || obs_a() !== exp_vec(0)) begin
        errors++; $display("FAIL hold_limit cyc=%0d grant got=%b exp=%b vec got=%h exp=%h", c, grant_a, g, obs_a(), exp_vec(0));
      end
    end
    req_a = 4'b0;
    tick(); tick();
  endtask

  task automatic test_early_release();
    req_a = 4'b0010;
    tick(); tick();
    req_a = 4'b0000;
    tick();
    checks++;
    if ({grant_a, dn_a} !== 5'b0000_1 || obs_a() !== exp_vec(0)) begin
      errors++; $display("FAIL early_release_turn got=%h exp=%h", obs_a(), exp_vec(0));
    end
    tick();
    checks++;
    if ({grant_a, dn_a, own_a} !== {4'b0000, 1'b1, 2'd1}) begin
      errors++; $display("FAIL early_release_idle got=%b exp=0000_1_01", {grant_a, dn_a, own_a});
    end
    req_a = 4'b0010;
    tick();
    checks++;
    if ({grant_a, own_a} !== {4'b0010, 2'd1} || obs_a() !== exp_vec(0)) begin
      errors++; $display("FAIL early_release_regrant got=%h exp=%h", obs_a(), exp_vec(0));
    end
  endtask

  task automatic test_reset_mid_drive();
    req_a = 4'b0;
    tick(); tick();
    req_a = 4'b0100;
    tick(); tick(); tick();
    checks++;
    if (grant_a !== 4'b0100) begin
      errors++; $display("FAIL mid_drive_setup grant got=%b exp=0100", grant_a);
    end
    rst_a_n = 1'b0;
    tick();
    checks++;
    if ({grant_a, own_a, dn_a} !== 7'b0000_00_1) begin
      errors++; $display("FAIL mid_drive_reset got=%b exp=0000_00_1", {grant_a, own_a, dn_a});
    end
    rst_a_n = 1'b1;
    req_a = 4'b1111;
    tick();
    checks++;
    if ({grant_a, own_a} !== {4'b0001, 2'd0} || obs_a() !== exp_vec(0)) begin
      errors++; $display("FAIL mid_drive_ptr_reset got=%h exp=%h", obs_a(), exp_vec(0));
    end
    req_a = 4'b0;
    tick(); tick();
  endtask

  task automatic test_contention();
    int exp_own[$];
    logic [3:0] g;
    for (int o = 0; o < 5; o++) begin
      if (o > 0) begin exp_own.push_back(-1); exp_own.push_back(-1); end
      for (int c = 0; c < 4; c++) exp_own.push_back(o % 4);
    end
    rst_b_n = 1'b0; tick(); rst_b_n = 1'b1;
    req_b = 4'b1111;
    foreach (exp_own[c]) begin
      din_b = $urandom;
      tick();
      g = (exp_own[c] < 0) ? 4'b0 : 4'(1 << exp_own[c]);
      checks++;
      if (grant_b !== g || !$onehot0(grant_b) || obs_b() !== exp_vec(1)) begin
        errors++; $display("FAIL contention cyc=%0d grant got=%b exp=%b vec got=%h exp=%h", c, grant_b, g, obs_b(), exp_vec(1));
      end
    end
    req_b = 4'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) req_a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) req_b = 4'($urandom_range(0, 15));
      din_a = $urandom; din_b = $urandom;
      rst_a_n = ($urandom_range(0, 59) != 0);
      rst_b_n = ($urandom_range(0, 59) != 0);
      tick();
      checks++;
      if (!$onehot0(grant_a) || obs_a() !== exp_vec(0)) begin
        errors++; $display("FAIL random_a cyc=%0d got=%h exp=%h", c, obs_a(), exp_vec(0));
      end
      checks++;
      if (!$onehot0(grant_b) || obs_b() !== exp_vec(1)) begin
        errors++; $display("FAIL random_b cyc=%0d got=%h exp=%h", c, obs_b(), exp_vec(1));
      end
    end
  endtask

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    req_a = 4'b0; req_b = 4'b0;
    din_a = 32'b0; din_b = 32'b0;
    test_reset();
    test_single();
    test_hold_limit();
    test_early_release();
    test_reset_mid_drive();
    test_contention();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
